// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the core-side FPU issue controller.
// Holds the issue FSM encoding, rounding-mode constants, fflags layout and fcsr struct.
package fpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } issue_state_t;

  localparam logic [2:0] FRM_DYN  = 3'b111;
  localparam logic [2:0] FRM_RSV5 = 3'b101;
  localparam logic [2:0] FRM_RSV6 = 3'b110;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef struct packed {
    logic [2:0] frm;
    logic [4:0] fflags;
  } fcsr_t;

  // Dynamic rm (3'b111) in the instruction defers to fcsr.frm.
  function automatic logic [2:0] resolve_rm(input logic [2:0] instr_rm,
                                            input logic [2:0] dyn_rm);
    return (instr_rm == FRM_DYN) ? dyn_rm : instr_rm;
  endfunction

  // A resolved rm of 111 means fcsr.frm itself held the dynamic code.
  function automatic logic rm_is_reserved(input logic [2:0] rm);
    return (rm == FRM_RSV5) || (rm == FRM_RSV6) || (rm == FRM_DYN);
  endfunction

endpackage

// File: rtl/fpu_fcsr.sv
// fcsr register: frm + sticky fflags, written by CSR access and OR-accumulated
// with FPU exception flags when an operation completes.
module fpu_fcsr
  import fpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       csr_wen,
  input  logic [7:0] csr_wdata,
  input  logic       acc_en,
  input  logic [4:0] acc_flags,
  output fcsr_t      fcsr
);

  fcsr_t      fcsr_nxt;
  logic [4:0] base_flags;
  logic [4:0] add_flags;

  // A CSR write replaces the sticky base, but flags completing in the same
  // cycle must still land on top of the written value.
  always_comb begin
    fcsr_nxt   = fcsr;
    base_flags = csr_wen ? csr_wdata[4:0] : fcsr.fflags;
    add_flags  = acc_en ? acc_flags : 5'b0;
    if (csr_wen) begin
      fcsr_nxt.frm = csr_wdata[7:5];
    end
    fcsr_nxt.fflags[FLAG_NV] = base_flags[FLAG_NV] | add_flags[FLAG_NV];
    fcsr_nxt.fflags[FLAG_DZ] = base_flags[FLAG_DZ] | add_flags[FLAG_DZ];
    fcsr_nxt.fflags[FLAG_OF] = base_flags[FLAG_OF] | add_flags[FLAG_OF];
    fcsr_nxt.fflags[FLAG_UF] = base_flags[FLAG_UF] | add_flags[FLAG_UF];
    fcsr_nxt.fflags[FLAG_NX] = base_flags[FLAG_NX] | add_flags[FLAG_NX];
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      fcsr <= '0;
    end else begin
      fcsr <= fcsr_nxt;
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Core-side FPU request initiator: issues one FP instruction at a time, stalls the
// core until the FPU responds or the wait times out, and owns the fcsr register.
module fpu_issue_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        instr_valid,
  input  logic [7:0]  instr_funct7,
  input  logic [4:0]  instr_rs1,
  input  logic [4:0]  instr_rs2,
  input  logic [4:0]  instr_rd,
  input  logic [2:0]  instr_frm,
  input  logic        instr_load,
  input  logic        instr_store,
  input  logic [31:0] load_data,
  input  logic        csr_wen,
  input  logic [7:0]  csr_wdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] store_data,
  output logic        illegal_instr,
  output logic        fpu_timeout,
  output logic [7:0]  fcsr_out,
  output logic [4:0]  f_rs1,
  output logic [4:0]  f_rs2,
  output logic [4:0]  f_rd,
  output logic [2:0]  frm_in,
  output logic [7:0]  f_funct_7,
  output logic        f_LW,
  output logic        f_SW,
  output logic        f_wen,
  output logic [31:0] dload_ext,
  input  logic [31:0] FPU_all_out,
  input  logic [4:0]  f_flags,
  input  logic        f_ready
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  issue_state_t     state;
  issue_state_t     state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             illegal_q;
  logic             timeout_q;

  fcsr_t            fcsr;
  logic [2:0]       rm_res;
  logic             rm_bad;
  logic             accept;
  logic             reject;
  logic             wait_limit;
  logic             req_out_en;

  logic [7:0]       req_funct7;
  logic [4:0]       req_rs1;
  logic [4:0]       req_rs2;
  logic [4:0]       req_rd;
  logic [2:0]       req_rm;
  logic             req_load;
  logic             req_store;
  logic [31:0]      req_ldata;
  logic [31:0]      rsp_data;
  logic [4:0]       rsp_flags;

  assign rm_res     = resolve_rm(instr_frm, fcsr.frm);
  assign rm_bad     = rm_is_reserved(rm_res);
  assign accept     = (state == ST_IDLE) && instr_valid && !rm_bad;
  assign reject     = (state == ST_IDLE) && instr_valid && rm_bad;
  // Last WAIT cycle is the TIMEOUT_CYCLES-th; f_ready on it still completes.
  assign wait_limit = (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (f_ready) begin
          state_nxt = ST_DONE;
        end else if (wait_limit) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      illegal_q <= reject;
      timeout_q <= (state == ST_WAIT) && !f_ready && wait_limit;
      if (state == ST_ISSUE) begin
        wait_cnt <= '0;
      end else if ((state == ST_WAIT) && !f_ready && !wait_limit) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Request and response payload; qualified by state, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_funct7 <= instr_funct7;
      req_rs1    <= instr_rs1;
      req_rs2    <= instr_rs2;
      req_rd     <= instr_rd;
      req_rm     <= rm_res;
      req_load   <= instr_load;
      req_store  <= instr_store;
      req_ldata  <= load_data;
    end
    if ((state == ST_WAIT) && f_ready) begin
      rsp_data  <= FPU_all_out;
      rsp_flags <= f_flags;
    end
  end

  fpu_fcsr u_fcsr (
    .clk       (clk),
    .n_rst     (n_rst),
    .csr_wen   (csr_wen),
    .csr_wdata (csr_wdata),
    .acc_en    (state == ST_DONE),
    .acc_flags (rsp_flags),
    .fcsr      (fcsr)
  );

  assign req_out_en = (state == ST_ISSUE) || (state == ST_WAIT);

  always_comb begin
    stall      = (state != ST_IDLE);
    wb_valid   = 1'b0;
    wb_rd      = 5'b0;
    store_data = 32'b0;
    f_rs1      = 5'b0;
    f_rs2      = 5'b0;
    f_rd       = 5'b0;
    frm_in     = 3'b0;
    f_funct_7  = 8'b0;
    f_LW       = 1'b0;
    f_SW       = 1'b0;
    f_wen      = 1'b0;
    dload_ext  = 32'b0;
    if (req_out_en) begin
      f_rs1     = req_rs1;
      f_rs2     = req_rs2;
      f_rd      = req_rd;
      frm_in    = req_rm;
      f_funct_7 = req_funct7;
      f_LW      = req_load;
      f_SW      = req_store;
      dload_ext = req_load ? req_ldata : 32'b0;
    end
    if (state == ST_ISSUE) begin
      f_wen = !req_store;
    end
    if (state == ST_DONE) begin
      wb_valid   = 1'b1;
      wb_rd      = req_rd;
      store_data = req_store ? rsp_data : 32'b0;
    end
  end

  assign illegal_instr = illegal_q;
  assign fpu_timeout   = timeout_q;
  assign fcsr_out      = fcsr;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level fcsr/issue model.
module tb_fpu_issue_ctrl;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        instr_valid;
  logic [7:0]  instr_funct7;
  logic [4:0]  instr_rs1, instr_rs2, instr_rd;
  logic [2:0]  instr_frm;
  logic        instr_load, instr_store;
  logic [31:0] load_data;
  logic        csr_wen;
  logic [7:0]  csr_wdata;
  logic        stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] store_data;
  logic        illegal_instr, fpu_timeout;
  logic [7:0]  fcsr_out;
  logic [4:0]  f_rs1, f_rs2, f_rd;
  logic [2:0]  frm_in;
  logic [7:0]  f_funct_7;
  logic        f_LW, f_SW, f_wen;
  logic [31:0] dload_ext;
  logic [31:0] FPU_all_out;
  logic [4:0]  f_flags;
  logic        f_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] m_frm;
  logic [4:0] m_fflags;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .n_rst(n_rst), .instr_valid(instr_valid), .instr_funct7(instr_funct7),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .instr_frm(instr_frm), .instr_load(instr_load), .instr_store(instr_store),
    .load_data(load_data), .csr_wen(csr_wen), .csr_wdata(csr_wdata),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .store_data(store_data),
    .illegal_instr(illegal_instr), .fpu_timeout(fpu_timeout), .fcsr_out(fcsr_out),
    .f_rs1(f_rs1), .f_rs2(f_rs2), .f_rd(f_rd), .frm_in(frm_in), .f_funct_7(f_funct_7),
    .f_LW(f_LW), .f_SW(f_SW), .f_wen(f_wen), .dload_ext(dload_ext),
    .FPU_all_out(FPU_all_out), .f_flags(f_flags), .f_ready(f_ready)
  );

  wire [59:0] f_req = {f_rs1, f_rs2, f_rd, frm_in, f_funct_7, f_LW, f_SW, dload_ext};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    instr_valid = 1'b0; instr_funct7 = '0; instr_rs1 = '0; instr_rs2 = '0; instr_rd = '0;
    instr_frm = '0; instr_load = 1'b0; instr_store = 1'b0; load_data = '0;
    csr_wen = 1'b0; csr_wdata = '0; FPU_all_out = '0; f_flags = '0; f_ready = 1'b0;
  endtask

  task automatic csr_write(input logic [7:0] wd);
    csr_wen = 1'b1; csr_wdata = wd;
    tick;
    csr_wen = 1'b0;
    m_frm = wd[7:5]; m_fflags = wd[4:0];
    n_checks++;
    if (fcsr_out !== {m_frm, m_fflags}) begin
      n_fail++; $display("FAIL csr_write fcsr_out: got %h expected %h", fcsr_out, {m_frm, m_fflags});
    end
  endtask

  // One full transaction; ready_k is the cycle f_ready is presented (>T+1 = never).
  task automatic run_op(input string name, input logic [7:0] funct7,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [2:0] frm, input logic ld, input logic st,
                        input logic [31:0] ldata, input int ready_k,
                        input logic [31:0] res, input logic [4:0] flags,
                        input logic csr_at_done, input logic [7:0] csr_wd);
    logic [2:0]  rm;
    logic [59:0] exp_req;
    logic        done;
    int          k;
    rm = (frm == 3'b111) ? m_frm : frm;
    instr_funct7 = funct7; instr_rs1 = rs1; instr_rs2 = rs2; instr_rd = rd;
    instr_frm = frm; instr_load = ld; instr_store = st; load_data = ldata;
    instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
    if (rm == 3'd5 || rm == 3'd6 || rm == 3'd7) begin
      n_checks++;
      if ({illegal_instr, stall, f_wen, f_req} !== {1'b1, 1'b0, 1'b0, 60'h0}) begin
        n_fail++; $display("FAIL %s illegal cycle1: got ill=%b stall=%b wen=%b req=%h expected 1 0 0 0",
                           name, illegal_instr, stall, f_wen, f_req);
      end
      tick;
      n_checks++;
      if ({illegal_instr, stall, f_wen} !== 3'b000) begin
        n_fail++; $display("FAIL %s illegal cycle2: got ill=%b stall=%b wen=%b expected 0 0 0",
                           name, illegal_instr, stall, f_wen);
      end
      return;
    end
    exp_req = {rs1, rs2, rd, rm, funct7, ld, st, (ld ? ldata : 32'h0)};
    instr_funct7 = 8'($urandom); instr_rs1 = 5'($urandom); instr_rd = 5'($urandom);
    load_data = $urandom;
    // cycle 1: ISSUE, f_ready must be ignored here
    n_checks++;
    if ({stall, f_wen, wb_valid, f_req} !== {1'b1, !st, 1'b0, exp_req}) begin
      n_fail++; $display("FAIL %s issue: got stall=%b wen=%b wb=%b req=%h expected 1 %b 0 %h",
                         name, stall, f_wen, wb_valid, f_req, !st, exp_req);
    end
    f_ready = 1'($urandom); FPU_all_out = $urandom; f_flags = 5'($urandom);
    instr_valid = 1'($urandom);
    tick;
    done = 1'b0;
    k = 2;
    while (!done && k <= T + 1) begin
      n_checks++;
      if ({stall, f_wen, wb_valid, f_req} !== {1'b1, 1'b0, 1'b0, exp_req}) begin
        n_fail++; $display("FAIL %s wait c%0d: got stall=%b wen=%b wb=%b req=%h expected 1 0 0 %h",
                           name, k, stall, f_wen, wb_valid, f_req, exp_req);
      end
      if (k == ready_k) begin
        f_ready = 1'b1; FPU_all_out = res; f_flags = flags; done = 1'b1;
      end else begin
        f_ready = 1'b0; FPU_all_out = $urandom; f_flags = 5'($urandom);
      end
      instr_valid = 1'($urandom);
      tick;
      k++;
    end
    f_ready = 1'b0; FPU_all_out = $urandom; f_flags = 5'($urandom);
    if (done) begin
      n_checks++;
      if ({wb_valid, wb_rd, store_data, stall, f_wen, f_req} !==
          {1'b1, rd, (st ? res : 32'h0), 1'b1, 1'b0, 60'h0}) begin
        n_fail++; $display("FAIL %s done: got wb=%b rd=%0d sd=%h stall=%b wen=%b req=%h expected 1 %0d %h 1 0 0",
                           name, wb_valid, wb_rd, store_data, stall, f_wen, f_req, rd, (st ? res : 32'h0));
      end
      if (csr_at_done) begin
        csr_wen = 1'b1; csr_wdata = csr_wd;
      end
      tick;
      instr_valid = 1'b0; csr_wen = 1'b0;
      if (csr_at_done) begin
        m_frm = csr_wd[7:5]; m_fflags = csr_wd[4:0] | flags;
      end else begin
        m_fflags = m_fflags | flags;
      end
      n_checks++;
      if ({fcsr_out, wb_valid, stall} !== {m_frm, m_fflags, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL %s post: got fcsr=%h wb=%b stall=%b expected %h 0 0",
                           name, fcsr_out, wb_valid, stall, {m_frm, m_fflags});
      end
    end else begin
      instr_valid = 1'b0;
      n_checks++;
      if ({fpu_timeout, stall, wb_valid, f_wen, f_req, fcsr_out} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 60'h0, m_frm, m_fflags}) begin
        n_fail++; $display("FAIL %s timeout: got to=%b stall=%b wb=%b req=%h fcsr=%h expected 1 0 0 0 %h",
                           name, fpu_timeout, stall, wb_valid, f_req, fcsr_out, {m_frm, m_fflags});
      end
      tick;
      n_checks++;
      if (fpu_timeout !== 1'b0) begin
        n_fail++; $display("FAIL %s timeout pulse: got %b expected 0", name, fpu_timeout);
      end
    end
  endtask

  task automatic do_reset;
    n_rst = 1'b0;
    tick;
    n_rst = 1'b1;
    m_frm = '0; m_fflags = '0;
  endtask

  task automatic test_reset;
    csr_write(8'hFF);
    n_rst = 1'b0;
    tick;
    n_checks++;
    if ({fcsr_out, stall, wb_valid, illegal_instr, fpu_timeout, f_wen, f_req, wb_rd, store_data} !== '0) begin
      n_fail++; $display("FAIL reset: got fcsr=%h stall=%b wb=%b wen=%b req=%h expected all zero",
                         fcsr_out, stall, wb_valid, f_wen, f_req);
    end
    n_rst = 1'b1;
    m_frm = '0; m_fflags = '0;
  endtask

  task automatic test_fadd;
    run_op("fadd", 8'h00, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 1'b0, 32'h0, 4,
           32'h40400000, 5'b00001, 1'b0, 8'h00);
    n_checks++;
    if (fcsr_out !== 8'h01) begin
      n_fail++; $display("FAIL fadd fcsr: got %h expected 01", fcsr_out);
    end
  endtask

  task automatic test_dyn_rm;
    csr_write(8'h40);
    run_op("dyn_rm", 8'h08, 5'd4, 5'd5, 5'd6, 3'b111, 1'b0, 1'b0, 32'h0, 3,
           32'h0, 5'b0, 1'b0, 8'h00);
    run_op("rsv_rm", 8'h08, 5'd4, 5'd5, 5'd6, 3'b101, 1'b0, 1'b0, 32'h0, 3,
           32'h0, 5'b0, 1'b0, 8'h00);
    csr_write(8'hC0);
    run_op("dyn_rsv", 8'h10, 5'd7, 5'd8, 5'd9, 3'b111, 1'b0, 1'b0, 32'h0, 3,
           32'h0, 5'b0, 1'b0, 8'h00);
  endtask

  task automatic test_store_load;
    do_reset;
    run_op("fsw", 8'h00, 5'd10, 5'd11, 5'd12, 3'b000, 1'b0, 1'b1, 32'h0, 2,
           32'h3F800000, 5'b0, 1'b0, 8'h00);
    run_op("flw", 8'h00, 5'd13, 5'd0, 5'd14, 3'b001, 1'b1, 1'b0, 32'hDEADBEEF, 3,
           32'h0, 5'b0, 1'b0, 8'h00);
  endtask

  task automatic test_csr_collision;
    do_reset;
    run_op("csr_coll", 8'h04, 5'd1, 5'd1, 5'd1, 3'b010, 1'b0, 1'b0, 32'h0, 2,
           32'h1, 5'b00010, 1'b1, 8'h04);
    n_checks++;
    if (fcsr_out !== 8'h06) begin
      n_fail++; $display("FAIL csr_coll fcsr: got %h expected 06", fcsr_out);
    end
  endtask

  task automatic test_timeout;
    csr_write(8'h2A);
    run_op("timeout", 8'h18, 5'd2, 5'd3, 5'd4, 3'b000, 1'b0, 1'b0, 32'h0, T + 2,
           32'h0, 5'b11111, 1'b0, 8'h00);
    run_op("ready_at_limit", 8'h18, 5'd2, 5'd3, 5'd4, 3'b000, 1'b0, 1'b0, 32'h0, T + 1,
           32'h0, 5'b10000, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid_wait;
    instr_funct7 = 8'h0C; instr_rs1 = 5'd3; instr_rs2 = 5'd4; instr_rd = 5'd5;
    instr_frm = 3'b000; instr_load = 1'b0; instr_store = 1'b0;
    instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
    tick;
    tick;
    n_rst = 1'b0;
    tick;
    n_rst = 1'b1;
    m_frm = '0; m_fflags = '0;
    n_checks++;
    if ({stall, f_wen, f_req, fcsr_out} !== '0) begin
      n_fail++; $display("FAIL rst_mid_wait: got stall=%b req=%h fcsr=%h expected 0 0 0",
                         stall, f_req, fcsr_out);
    end
    f_ready = 1'b1; FPU_all_out = 32'h12345678; f_flags = 5'b11111;
    tick;
    f_ready = 1'b0;
    tick;
    n_checks++;
    if ({wb_valid, stall, fcsr_out} !== '0) begin
      n_fail++; $display("FAIL late_ready: got wb=%b stall=%b fcsr=%h expected 0 0 00",
                         wb_valid, stall, fcsr_out);
    end
  endtask

  task automatic test_back_to_back;
    run_op("b2b_a", 8'h00, 5'd1, 5'd2, 5'd20, 3'b011, 1'b0, 1'b0, 32'h0, 2,
           32'h0, 5'b00100, 1'b0, 8'h00);
    run_op("b2b_b", 8'h01, 5'd3, 5'd4, 5'd21, 3'b100, 1'b0, 1'b1, 32'h0, 2,
           32'hA5A5A5A5, 5'b01000, 1'b0, 8'h00);
  endtask

  task automatic test_random;
    int sel;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        csr_write(8'($urandom));
      end
      sel = $urandom_range(0, 2);
      run_op("random", 8'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             3'($urandom), (sel == 1), (sel == 2), $urandom, $urandom_range(2, T + 2),
             $urandom, 5'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    clear_inputs;
    n_rst = 1'b0;
    m_frm = '0; m_fflags = '0;
    tick;
    tick;
    n_rst = 1'b1;
    test_reset;
    test_fadd;
    test_dyn_rm;
    test_store_load;
    test_csr_collision;
    test_timeout;
    test_reset_mid_wait;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Core-side initiator of the FPU request/response interface. Accepts one decoded floating-point instruction at a time from the pipeline, drives the FPU request signals, stalls the core until the FPU reports completion, and returns the result or store data. Owns the fcsr register (frm + sticky fflags), resolving dynamic rounding mode and accumulating exception flags. Sits between decode/execute and the FPU, one instance per core.

## Interface
- TIMEOUT_CYCLES, 64: max WAIT cycles before abandoning a request (≥2)
- clk  in  1  clock
- n_rst  in  1  reset; synchronous, active-low
- instr_valid  in  1  decoded FP instruction present
- instr_funct7  in  8  operation select
- instr_rs1 / instr_rs2 / instr_rd  in  5 each  register indices
- instr_frm  in  3  instruction rm field; 3'b111 = dynamic
- instr_load / instr_store  in  1 each  FLW / FSW (mutually exclusive)
- load_data  in  32  memory data for FLW
- csr_wen  in  1  CSR write to fcsr
- csr_wdata  in  8  {frm[2:0], fflags[4:0]}
- stall  out  1  core must hold; high whenever state ≠ IDLE
- wb_valid  out  1  one-cycle completion pulse
- wb_rd  out  5  destination of completed op
- store_data  out  32  FSW data, valid with wb_valid
- illegal_instr  out  1  one-cycle pulse, reserved rounding mode
- fpu_timeout  out  1  one-cycle pulse, request abandoned
- fcsr_out  out  8  current fcsr
- f_rs1 / f_rs2 / f_rd  out  5 each  to FPU
- frm_in  out  3  resolved rounding mode
- f_funct_7  out  8, f_LW / f_SW / f_wen  out  1 each
- dload_ext  out  32  load data to FPU
- FPU_all_out  in  32, f_flags  in  5, f_ready  in  1  FPU response

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: on instr_valid, resolve rm = (instr_frm==3'b111) ? fcsr.frm : instr_frm. If rm ∈ {101,110,111} → pulse illegal_instr next cycle, stay IDLE, no FPU signals. Else latch all request fields, → ISSUE.
- ISSUE: f_wen=1 for this cycle only (0 for stores); f_LW/f_SW per instruction; f_ready ignored. → WAIT.
- WAIT: request fields held stable. f_ready=1 → capture FPU_all_out, f_flags → DONE. Counter reaches TIMEOUT_CYCLES → pulse fpu_timeout, → IDLE, flags not accumulated.
- DONE: wb_valid=1, wb_rd=latched rd, store_data=captured value (stores), fflags |= captured flags at end of cycle. → IDLE.
- fcsr: csr_wen writes frm and fflags. Simultaneous csr_wen and DONE accumulation: fflags = csr_wdata[4:0] | captured flags; frm = csr_wdata[7:5].
- Outside ISSUE/WAIT all f_* outputs are 0.

## Timing
- Reset (n_rst low at rising edge): state IDLE, fcsr 8'h00, all outputs 0, counter 0. Reset mid-WAIT drops the request; late f_ready after reset is ignored.
- Accept edge = cycle 0; ISSUE cycle 1; WAIT from cycle 2; f_ready first sampled cycle 2. f_ready at cycle k → wb_valid at cycle k+1; IDLE at k+2, next instruction accepted at k+2 earliest.
- Minimum latency accept→wb_valid: 3 cycles.
- stall combinational from state; high cycles 1..k+1.
- Counter cleared on entry to WAIT, increments each WAIT cycle without f_ready; f_ready on the same cycle the counter hits limit wins (completion).
- illegal_instr pulses cycle 1 with stall low.

## Structure
- Package fpu_ctrl_pkg: state enum, FRM_DYN=3'b111, reserved rm constants, fflags bit indices (NV=4, DZ=3, OF=2, UF=1, NX=0), fcsr struct.
- Sub-module fpu_fcsr: fcsr register with CSR write and sticky OR accumulation.

## Test plan
- Reset with fcsr preloaded 8'hFF → fcsr_out=0, stall=0, all f_* 0.
- FADD rs1=1 rs2=2 rd=3 frm=000, f_ready on cycle 4 with f_flags=00001 → f_wen only cycle 1, wb_valid cycle 5 wb_rd=3, fcsr_out=8'h01.
- csr write frm=010; instr_frm=111 → frm_in=010; instr_frm=101 → illegal_instr pulse, no f_wen.
- FSW, FPU_all_out=32'h3F800000, f_ready cycle 2 → f_SW=1, f_wen=0, store_data=32'h3F800000 at cycle 3.
- csr_wen wdata 8'h04 coincident with DONE flags 00010 → fcsr_out=8'h06.
- f_ready never asserted, TIMEOUT_CYCLES=8 → fpu_timeout pulse, stall drops, fflags unchanged; reset mid-WAIT → IDLE next cycle.
